uart_transmit_fsm: RTL and testbench
====================================

UART_TRANSMIT_FSM -- requirements
Module: uart_transmit_fsm

Interface
REQ-001 SHALL: MCLK  input  1  system clock; all sequential logic on its rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high.
REQ-003 SHALL: BITEN  input  1  one-MCLK-wide bit-period tick from the baud generator.
REQ-004 SHALL: wUCPEN, wUCPAR, wUCMSB, wUC7BIT, wUCSPB  input  1 each  parity enable; even parity when 1; MSB first; 7-bit data; two stop bits.
REQ-005 SHALL: TxData  input  8  software write value for UCAxTXBUF.
REQ-006 SHALL: TxLoad  input  1  one-MCLK pulse marking a TXBUF write.
REQ-007 SHALL: Tx  output  1  serial line; idle level 1.
REQ-008 SHALL: TxBEN  output  1  baud-generator run request.
REQ-009 SHALL: TxBusy  output  1  frame in progress.
REQ-010 SHALL: rSetTxIFG  output  1  one-MCLK pulse when TXBUF moves to the shift register.
REQ-011 SHALL: rSetTxCPTIFG  output  1  one-MCLK pulse when the final stop bit ends with no pending data.

Function
REQ-012 SHALL: states sIDLE, sSTART, sBIT1..sBIT8, sPARITY, sSTOP2, sSTOP1, encoded in 4 bits; any illegal encoding returns to sIDLE on the next BITEN.
REQ-013 SHALL: state advances only on MCLK edges with BITEN=1, and Tx changes on that same edge; each bit lasts exactly one BITEN interval.
REQ-014 SHALL: TxLoad=1 latches TxData into a one-entry holding buffer and sets bufValid; a load while bufValid=1 overwrites the buffer.
REQ-015 SHALL: in sIDLE with bufValid=1 and BITEN=1, perform all of the following:
- go to sSTART and drive Tx=0;
- copy the buffer into the shift register;
- snapshot the five configuration inputs;
- clear bufValid;
- pulse rSetTxIFG.
REQ-016 SHALL: a TxLoad coincident with the REQ-015 transfer leaves bufValid=1 holding the new value.
REQ-017 SHALL: data order is LSB first when wUCMSB=0 (TxData[0] first) and MSB first otherwise (TxData[7] first, or TxData[6] first in 7-bit mode).
REQ-018 SHALL: sequence after sSTART:
- sBIT1..sBIT7, then sBIT8 only when 8-bit mode;
- then sPARITY if PEN=1;
- then sSTOP2 if SPB=1;
- then sSTOP1.
REQ-019 SHALL: in sPARITY, Tx = XOR of the transmitted data bits when PAR=1 (even), and its inverse when PAR=0 (odd).
REQ-020 SHALL: Tx=1 in sSTOP2 and sSTOP1.
REQ-021 SHALL: leaving sSTOP1 with bufValid=1 goes directly to sSTART with no idle bit (back-to-back) and applies REQ-015 actions.
REQ-022 SHALL: leaving sSTOP1 with bufValid=0 goes to sIDLE and pulses rSetTxCPTIFG.
REQ-023 SHALL: configuration changes mid-frame have no effect until the next frame's snapshot.
REQ-024 SHALL: TxBusy=1 in every state except sIDLE.
REQ-025 SHALL: TxBEN = TxBusy OR bufValid, registered.
REQ-026 SHALL: BITEN in sIDLE with bufValid=0 is ignored.

Reset
REQ-027 SHALL: reset forces the following immediately, including mid-frame:
- state=sIDLE, Tx=1, bufValid=0, shift register=0, configuration snapshot=0;
- TxBusy=0, TxBEN=0, rSetTxIFG=0, rSetTxCPTIFG=0.
REQ-028 SHALL: a TxLoad asserted during reset is discarded.

Structure
REQ-029 SHALL: state localparams and the frame-length rule belong in the shared eUSCI parameter include, so the receive and transmit FSMs share one encoding.
REQ-030 SHALL: the design is a single module; the bit-order/7-bit data formatter is the only natural sub-module, named uart_tx_format (combinational: TxData, MSB, 7BIT -> 8-bit LSB-first shift word).

Verification
REQ-031 SHALL: load 0x55, 8N1 LSB -> Tx per bit 0,1,0,1,0,1,0,1,0,1 then idle 1; one rSetTxIFG and one rSetTxCPTIFG pulse.
REQ-032 SHALL: load 0xA3, 8-bit even parity, 2 stop, MSB first -> Tx 0,1,0,1,0,0,0,1,1,0(parity),1,1.
REQ-033 SHALL: load 0x41, 7-bit odd parity, 1 stop, LSB first -> Tx 0,1,0,0,0,0,0,1,1(parity),1; sBIT8 never entered.
REQ-034 SHALL: load 0x01, then 0x02 during bit 3 -> two contiguous frames with no idle bit between, two rSetTxIFG pulses, and rSetTxCPTIFG only after the second frame.
REQ-035 SHALL: assert reset during sBIT4 of 0xFF -> Tx=1 and TxBusy=0 within the same cycle; a new load of 0x0F afterwards transmits correctly.
REQ-036 SHALL: toggle wUCPEN mid-frame -> current frame length is unchanged and the next frame applies the new setting.

Source files
------------

// File: rtl/uart_transmit_fsm_pkg.sv
// uart_transmit_fsm_pkg: shared eUSCI UART state encoding, frame config and frame-length rule
package uart_transmit_fsm_pkg;
  localparam logic [3:0] sIDLE   = 4'd0;
  localparam logic [3:0] sSTART  = 4'd1;
  localparam logic [3:0] sBIT1   = 4'd2;
  localparam logic [3:0] sBIT2   = 4'd3;
  localparam logic [3:0] sBIT3   = 4'd4;
  localparam logic [3:0] sBIT4   = 4'd5;
  localparam logic [3:0] sBIT5   = 4'd6;
  localparam logic [3:0] sBIT6   = 4'd7;
  localparam logic [3:0] sBIT7   = 4'd8;
  localparam logic [3:0] sBIT8   = 4'd9;
  localparam logic [3:0] sPARITY = 4'd10;
  localparam logic [3:0] sSTOP2  = 4'd11;
  localparam logic [3:0] sSTOP1  = 4'd12;

  typedef struct packed {
    logic pen;
    logic par;
    logic msb;
    logic b7;
    logic spb;
  } cfg_t;

  // Successor state on a bit tick; illegal encodings fall back to idle.
  function automatic logic [3:0] tx_next(input logic [3:0] st, input cfg_t c, input logic bufv);
    logic [3:0] tail;
    tail = c.spb ? sSTOP2 : sSTOP1;
    case (st)
      sIDLE:   tx_next = bufv ? sSTART : sIDLE;
      sSTART, sBIT1, sBIT2, sBIT3, sBIT4, sBIT5, sBIT6:
               tx_next = st + 4'd1;
      sBIT7:   tx_next = c.b7 ? (c.pen ? sPARITY : tail) : sBIT8;
      sBIT8:   tx_next = c.pen ? sPARITY : tail;
      sPARITY: tx_next = tail;
      sSTOP2:  tx_next = sSTOP1;
      sSTOP1:  tx_next = bufv ? sSTART : sIDLE;
      default: tx_next = sIDLE;
    endcase
  endfunction
endpackage

// File: rtl/uart_transmit_fsm_if.sv
// uart_transmit_fsm_if: TXBUF write, config and serial-line signals of the UART transmitter
interface uart_transmit_fsm_if;
  logic       BITEN;
  logic       wUCPEN;
  logic       wUCPAR;
  logic       wUCMSB;
  logic       wUC7BIT;
  logic       wUCSPB;
  logic [7:0] TxData;
  logic       TxLoad;
  logic       Tx;
  logic       TxBEN;
  logic       TxBusy;
  logic       rSetTxIFG;
  logic       rSetTxCPTIFG;

  modport master (
    output BITEN, wUCPEN, wUCPAR, wUCMSB, wUC7BIT, wUCSPB, TxData, TxLoad,
    input  Tx, TxBEN, TxBusy, rSetTxIFG, rSetTxCPTIFG
  );

  modport slave (
    input  BITEN, wUCPEN, wUCPAR, wUCMSB, wUC7BIT, wUCSPB, TxData, TxLoad,
    output Tx, TxBEN, TxBusy, rSetTxIFG, rSetTxCPTIFG
  );
endinterface

// File: rtl/uart_tx_format.sv
// uart_tx_format: reorders a data byte into an LSB-first word, masking bit 7 in 7-bit mode
module uart_tx_format (
  input  logic [7:0] TxData,
  input  logic       wUCMSB,
  input  logic       wUC7BIT,
  output logic [7:0] word
);
  logic [7:0] r8;
  logic [6:0] r7;
  for (genvar i = 0; i < 8; i++) begin : g_r8
    assign r8[i] = TxData[7-i];
  end
  for (genvar i = 0; i < 7; i++) begin : g_r7
    assign r7[i] = TxData[6-i];
  end
  assign word = wUCMSB ? (wUC7BIT ? {1'b0, r7} : r8)
                       : (wUC7BIT ? {1'b0, TxData[6:0]} : TxData);
endmodule

// File: rtl/uart_transmit_fsm.sv
// uart_transmit_fsm: eUSCI UART transmit framer with one-entry TXBUF and back-to-back frames
module uart_transmit_fsm
  import uart_transmit_fsm_pkg::*;
(
  input logic MCLK,
  input logic reset,
  uart_transmit_fsm_if.slave bus
);
  logic [3:0] st, nst;
  logic [7:0] buff, sh, word;
  logic [2:0] bi;
  logic       bufv, bufv_n, busy_n, xfer, tx, ntx, txben, ifg, cpt;
  cfg_t       cfg, cin;

  assign cin    = '{pen: bus.wUCPEN, par: bus.wUCPAR, msb: bus.wUCMSB, b7: bus.wUC7BIT, spb: bus.wUCSPB};
  assign xfer   = bus.BITEN && bufv && (st == sIDLE || st == sSTOP1);
  assign nst    = tx_next(st, cfg, bufv);
  assign bi     = 3'(nst - sBIT1);
  assign bufv_n = bus.TxLoad | (bufv & ~xfer);
  assign busy_n = (bus.BITEN ? nst : st) != sIDLE;

  // Formatting runs off the frame snapshot so mid-frame config writes cannot disturb it.
  uart_tx_format u_fmt (
    .TxData (sh),
    .wUCMSB (cfg.msb),
    .wUC7BIT(cfg.b7),
    .word   (word)
  );

  always_comb begin
    ntx = nst == sSTART ? 1'b0
        : (nst >= sBIT1 && nst <= sBIT8) ? word[bi]
        : nst == sPARITY ? (^word ^ ~cfg.par)
        : 1'b1;
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      st    <= sIDLE;
      tx    <= 1'b1;
      buff  <= '0;
      bufv  <= 1'b0;
      sh    <= '0;
      cfg   <= '0;
      txben <= 1'b0;
      ifg   <= 1'b0;
      cpt   <= 1'b0;
    end else begin
      if (bus.TxLoad) buff <= bus.TxData;
      bufv  <= bufv_n;
      txben <= busy_n | bufv_n;
      ifg   <= xfer;
      cpt   <= bus.BITEN && st == sSTOP1 && !bufv;
      if (bus.BITEN) begin
        st <= nst;
        tx <= ntx;
      end
      if (xfer) begin
        sh  <= buff;
        cfg <= cin;
      end
    end
  end

  assign bus.Tx           = tx;
  assign bus.TxBusy       = st != sIDLE;
  assign bus.TxBEN        = txben;
  assign bus.rSetTxIFG    = ifg;
  assign bus.rSetTxCPTIFG = cpt;
endmodule

// File: tb/tb_uart_transmit_fsm.sv
// tb_uart_transmit_fsm: scoreboard bench comparing every transmitted bit against a frame model
module tb_uart_transmit_fsm;
  typedef struct {
    logic v;
    logic gap_ok;
  } exp_t;

  logic MCLK = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0, n_err = 0, n_ifg = 0, n_cpt = 0, bcnt = 0;
  logic c_pen = 0, c_par = 0, c_msb = 0, c_b7 = 0, c_spb = 0;
  exp_t q[$];

  uart_transmit_fsm_if u_if ();

  uart_transmit_fsm u_dut (
    .MCLK (MCLK),
    .reset(reset),
    .bus  (u_if)
  );

  always #5 MCLK = ~MCLK;

  always @(negedge MCLK) begin
    bcnt = (bcnt == 3) ? 0 : bcnt + 1;
    u_if.BITEN = (bcnt == 0);
  end

  always @(negedge MCLK) begin
    if (u_if.rSetTxIFG) n_ifg++;
    if (u_if.rSetTxCPTIFG) n_cpt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bits are sampled after each tick edge while a frame is on the line.
  always @(posedge MCLK) begin
    if (u_if.BITEN && !reset) begin
      #1;
      if (u_if.TxBusy) begin
        if (q.size() == 0) check("extra_bit", u_if.TxBusy, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("tx_bit", u_if.Tx, e.v);
        end
      end else if (q.size() > 0 && !q[0].gap_ok) check("gap", u_if.TxBusy, 1);
    end
  end

  task automatic set_cfg(input logic p, input logic a, input logic m, input logic s7, input logic s2);
    c_pen = p; c_par = a; c_msb = m; c_b7 = s7; c_spb = s2;
    u_if.wUCPEN = p; u_if.wUCPAR = a; u_if.wUCMSB = m; u_if.wUC7BIT = s7; u_if.wUCSPB = s2;
  endtask

  task automatic push_frame(input logic [7:0] d, input logic gap_ok);
    int   n;
    logic b, p;
    n = c_b7 ? 7 : 8;
    p = 1'b0;
    q.push_back('{v: 1'b0, gap_ok: gap_ok});
    for (int i = 0; i < n; i++) begin
      b = c_msb ? d[n-1-i] : d[i];
      p ^= b;
      q.push_back('{v: b, gap_ok: 1'b0});
    end
    if (c_pen) q.push_back('{v: c_par ? p : ~p, gap_ok: 1'b0});
    if (c_spb) q.push_back('{v: 1'b1, gap_ok: 1'b0});
    q.push_back('{v: 1'b1, gap_ok: 1'b0});
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge MCLK);
    u_if.TxData = d;
    u_if.TxLoad = 1'b1;
    @(negedge MCLK);
    u_if.TxLoad = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic b2b);
    push_frame(d, !b2b);
    load(d);
  endtask

  task automatic wait_ifg();
    for (int i = 0; i < 300; i++) begin
      @(negedge MCLK);
      if (u_if.rSetTxIFG) break;
    end
    check("ifg_wait", u_if.rSetTxIFG, 1);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      do @(posedge MCLK); while (!u_if.BITEN);
    end
    @(negedge MCLK);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 800; i++) begin
      @(negedge MCLK);
      if (q.size() == 0 && !u_if.TxBusy) break;
    end
    check("done_wait", 32'(q.size() == 0 && !u_if.TxBusy), 1);
    repeat (2) @(negedge MCLK);
    #1;
  endtask

  initial begin
    int bi, bc;
    u_if.BITEN = 1'b0;
    u_if.TxData = 8'h99;
    u_if.TxLoad = 1'b1;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(negedge MCLK);
    check("rst_tx", u_if.Tx, 1);
    check("rst_busy", u_if.TxBusy, 0);
    check("rst_ben", u_if.TxBEN, 0);
    check("rst_ifg", u_if.rSetTxIFG, 0);
    check("rst_cpt", u_if.rSetTxCPTIFG, 0);
    reset = 1'b0;
    u_if.TxLoad = 1'b0;
    repeat (10) @(negedge MCLK);
    check("load_in_rst_ben", u_if.TxBEN, 0);
    check("load_in_rst_busy", u_if.TxBusy, 0);
    check("idle_tx", u_if.Tx, 1);

    bi = n_ifg; bc = n_cpt;
    set_cfg(0, 0, 0, 0, 0);
    send(8'h55, 0);
    @(negedge MCLK);
    check("ben_pending", u_if.TxBEN, 1);
    wait_done();
    check("f55_ifg", n_ifg - bi, 1);
    check("f55_cpt", n_cpt - bc, 1);
    check("f55_idle", u_if.Tx, 1);
    check("f55_ben", u_if.TxBEN, 0);

    set_cfg(1, 1, 1, 0, 1);
    send(8'hA3, 0);
    wait_done();

    bc = n_cpt;
    set_cfg(1, 0, 0, 1, 0);
    send(8'h41, 0);
    wait_done();
    check("f41_cpt", n_cpt - bc, 1);

    bi = n_ifg; bc = n_cpt;
    set_cfg(0, 0, 0, 0, 0);
    send(8'h01, 0);
    wait_ifg();
    ticks(3);
    send(8'h02, 1);
    wait_ifg();
    check("b2b_no_early_cpt", n_cpt - bc, 0);
    wait_done();
    check("b2b_ifg", n_ifg - bi, 2);
    check("b2b_cpt", n_cpt - bc, 1);

    send(8'hFF, 0);
    wait_ifg();
    ticks(4);
    #1;
    reset = 1'b1;
    q.delete();
    #1;
    check("midrst_tx", u_if.Tx, 1);
    check("midrst_busy", u_if.TxBusy, 0);
    check("midrst_ben", u_if.TxBEN, 0);
    repeat (2) @(negedge MCLK);
    reset = 1'b0;
    bc = n_cpt;
    send(8'h0F, 0);
    wait_done();
    check("f0f_cpt", n_cpt - bc, 1);

    bi = n_ifg;
    set_cfg(0, 0, 0, 0, 0);
    send(8'h3C, 0);
    wait_ifg();
    ticks(2);
    set_cfg(1, 1, 0, 0, 0);
    send(8'hC3, 1);
    wait_done();
    check("pen_toggle_ifg", n_ifg - bi, 2);

    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
